// File: rtl/cic_comp_fir.sv
// Droop compensator that follows a CIC decimator: a 7-tap symmetric FIR evaluated
// with one shared multiplier and accumulator, producing one output per accepted sample.
module cic_comp_fir #(
  parameter int NIN  = 17,
  parameter int NOUT = 17
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en,
  input  logic signed [NIN-1:0]  din,
  input  logic                   valid,
  output logic                   ready,
  output logic signed [NOUT-1:0] dout,
  output logic                   dout_valid,
  output logic                   overrun
);

  localparam int AW = NIN + 8;
  localparam int SW = (AW > NOUT + 1) ? AW : NOUT + 1;
  localparam logic signed [SW-1:0] YMAX = SW'((64'sd1 <<< (NOUT - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] YMIN = -YMAX - SW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  logic [1:0]            state;
  logic [2:0]            tap;
  logic signed [AW-1:0]  acc;
  logic [6:0][NIN-1:0]   dl;

  logic signed [7:0]     coef;
  logic signed [NIN-1:0] xk;
  logic signed [AW-1:0]  prod;
  logic signed [AW-1:0]  acc_rnd;
  logic signed [AW-1:0]  y;
  logic signed [SW-1:0]  y_ext;
  logic signed [SW-1:0]  y_sat;

  assign ready = (state == S_IDLE) && en;

  // Symmetric coefficient ROM, indexed by the tap counter.
  always_comb begin
    coef = 8'sd44;
    case (tap)
      3'd0, 3'd6: coef = -8'sd1;
      3'd1, 3'd5: coef = 8'sd3;
      3'd2, 3'd4: coef = -8'sd8;
      default:    coef = 8'sd44;
    endcase
  end

  assign xk   = $signed(dl[tap]);
  assign prod = AW'(coef) * AW'(xk);

  // Round half up then arithmetic shift by 5 removes the DC gain of 32.
  assign acc_rnd = acc + AW'(16);
  assign y       = acc_rnd >>> 5;
  assign y_ext   = SW'(y);

  always_comb begin
    y_sat = y_ext;
    if (y_ext > YMAX)      y_sat = YMAX;
    else if (y_ext < YMIN) y_sat = YMIN;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_IDLE;
      tap        <= '0;
      acc        <= '0;
      dl         <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      if (valid && !ready) overrun <= 1'b1;
      // en low freezes everything in place; the MAC resumes where it stopped.
      if (en) begin
        case (state)
          S_IDLE: begin
            if (valid) begin
              dl    <= {dl[5:0], din};
              acc   <= '0;
              tap   <= '0;
              state <= S_MAC;
            end
          end
          S_MAC: begin
            acc <= acc + prod;
            tap <= tap + 3'd1;
            if (tap == 3'd6) state <= S_OUT;
          end
          S_OUT: begin
            dout       <= y_sat[NOUT-1:0];
            dout_valid <= 1'b1;
            state      <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Randomized scoreboard bench for cic_comp_fir: a direct-form FIR model predicts each
// output and its arrival cycle; a negedge monitor checks value, timing and hold.
module tb_cic_comp_fir;
  localparam int NIN  = 17;
  localparam int NOUT = 17;
  localparam int H[7] = '{-1, 3, -8, 44, -8, 3, -1};

  logic clk = 1'b0, rstn = 1'b0, en = 1'b0, valid = 1'b0;
  logic signed [NIN-1:0]  din = '0;
  logic                   ready, dout_valid, overrun;
  logic signed [NOUT-1:0] dout;

  cic_comp_fir #(.NIN(NIN), .NOUT(NOUT)) dut (
    .clk(clk), .rstn(rstn), .en(en), .din(din), .valid(valid),
    .ready(ready), .dout(dout), .dout_valid(dout_valid), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int tests = 0, fails = 0;
  longint exp_q[$];
  int     cyc_q[$];
  longint hist[7];
  longint last_dout = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input longint act, input longint req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic longint model();
    longint s, r, lim;
    s = 0;
    for (int k = 0; k < 7; k++) s += H[k] * hist[k];
    r   = (s + 16) >>> 5;
    lim = longint'(1) <<< (NOUT - 1);
    if (r > lim - 1) r = lim - 1;
    if (r < -lim)    r = -lim;
    return r;
  endfunction

  // Monitor: every strobe must match the oldest prediction, in value and cycle.
  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      last_dout = 0;
    end else if (dout_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_dout_valid", 1, 0);
      end else begin
        check("dout", longint'(dout), exp_q.pop_front());
        check("latency_cycle", cyc, cyc_q.pop_front());
      end
      last_dout = longint'(dout);
    end else if (longint'(dout) != last_dout) begin
      check("dout_hold", longint'(dout), last_dout);
      last_dout = longint'(dout);
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one strobe; returns just after the accepting edge.
  task automatic send_exp(input longint d, input longint e, input int extra);
    for (int k = 6; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = d;
    exp_q.push_back(e);
    cyc_q.push_back(cyc + 9 + extra);
    din   = d[NIN-1:0];
    valid = 1'b1;
    @(posedge clk);
    #1;
    valid = 1'b0;
  endtask

  task automatic send(input longint d, input int extra);
    longint e;
    for (int k = 6; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = d;
    e = model();
    for (int k = 0; k < 6; k++) hist[k] = hist[k+1];
    hist[6] = 0;
    send_exp(d, e, extra);
  endtask

  task automatic impulse();
    longint lit[8] = '{-31, 94, -250, 1375, -250, 94, -31, 0};
    for (int i = 0; i < 8; i++) begin
      send_exp((i == 0) ? 1000 : 0, lit[i], 0);
      idle(9);
    end
  endtask

  initial begin
    for (int k = 0; k < 7; k++) hist[k] = 0;
    idle(3);
    check("rst_dout", longint'(dout), 0);
    check("rst_dout_valid", dout_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_ready_en0", ready, 0);
    rstn = 1'b1;
    idle(1);
    check("ready_en0", ready, 0);
    en = 1'b1;
    #1;
    check("ready_en1", ready, 1);

    impulse();

    for (int i = 0; i < 10; i++) begin send(1000, 0); idle(9); end
    for (int i = 0; i < 8; i++)  begin send(65535, 0); idle(8); end
    for (int i = 0; i < 8; i++)  begin send(-65536, 0); idle(8); end
    check("overrun_quiet", overrun, 0);

    for (int i = 0; i < 40; i++) begin
      longint r;
      r = longint'($urandom_range(0, (1 << NIN) - 1)) - (longint'(1) <<< (NIN - 1));
      send(r, 0);
      idle($urandom_range(8, 12));
    end

    // Strobe during MAC must be dropped and flagged.
    send(12345, 0);
    idle(2);
    check("ready_busy", ready, 0);
    din   = 17'sd999;
    valid = 1'b1;
    idle(1);
    valid = 1'b0;
    check("overrun_set", overrun, 1);
    idle(7);
    send(-2222, 0);
    idle(9);
    check("overrun_sticky", overrun, 1);

    // Five disabled edges mid-MAC push the strobe out by five cycles.
    send(30000, 5);
    idle(2);
    en = 1'b0;
    #1;
    check("ready_en_low", ready, 0);
    idle(5);
    en = 1'b1;
    idle(8);
    send(-4000, 0);
    idle(9);

    // Reset in the middle of MAC abandons the pending output.
    send(5555, 0);
    idle(2);
    rstn = 1'b0;
    void'(exp_q.pop_back());
    void'(cyc_q.pop_back());
    for (int k = 0; k < 7; k++) hist[k] = 0;
    idle(2);
    rstn = 1'b1;
    #1;
    check("mid_rst_dout", longint'(dout), 0);
    check("mid_rst_dout_valid", dout_valid, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_ready", ready, 1);
    idle(10);
    impulse();

    idle(12);
    check("pending_outputs", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d outputs pending", exp_q.size());
    $fatal(1, "watchdog");
  end
endmodule
